// File: rtl/dps_strap_ctrl_if.sv
// rtl/dps_strap_ctrl_if.sv - pad strap, SRST request and sequencer output bundle
interface dps_strap_ctrl_if;
    logic       strap_dps6_i;
    logic       strap_dps7_i;
    logic       srst_ni;
    logic       rst_sys_no;
    logic       dps_spi_sel_o;
    logic       bootstrap_o;
    logic       mode_valid_o;
    logic [7:0] srst_cnt_o;
    logic [1:0] state_o;

    modport master (
        output strap_dps6_i, strap_dps7_i, srst_ni,
        input  rst_sys_no, dps_spi_sel_o, bootstrap_o, mode_valid_o, srst_cnt_o, state_o
    );

    modport slave (
        input  strap_dps6_i, strap_dps7_i, srst_ni,
        output rst_sys_no, dps_spi_sel_o, bootstrap_o, mode_valid_o, srst_cnt_o, state_o
    );
endinterface

// File: rtl/dps_strap_ctrl.sv
// rtl/dps_strap_ctrl.sv - debug pad strap sampler, latch and SRST stretching reset sequencer
module dps_strap_ctrl #(
    parameter int SyncStages        = 2,
    parameter int DebounceCycles    = 16,
    parameter int SrstStretchCycles = 64
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    dps_strap_ctrl_if.slave pads
);
    localparam int DcntW = $clog2(DebounceCycles);
    localparam int ScntW = $clog2(SrstStretchCycles + 1);

    typedef enum logic [1:0] {
        ST_RESET  = 2'd0,
        ST_SAMPLE = 2'd1,
        ST_RUN    = 2'd2,
        ST_SRST   = 2'd3
    } state_e;

    state_e                 state_q, state_d;
    logic [SyncStages-1:0]  sync6_q, sync7_q, syncr_q;
    logic [1:0]             s_strap;
    logic                   s_srst_n;
    logic [1:0]             cand_q, cand_d;
    logic [DcntW-1:0]       dcnt_q, dcnt_d;
    logic [ScntW-1:0]       scnt_q, scnt_d;
    logic                   rst_sys_q;
    logic                   spi_q, spi_d;
    logic                   boot_q, boot_d;
    logic                   valid_q, valid_d;
    logic [7:0]             cnt_q, cnt_d;

    // Synchronisers stay at their reset value through the RESET->SAMPLE edge
    always_ff @(posedge clk_i) begin
        if (!rst_ni || state_q == ST_RESET) begin
            sync6_q <= '0;
            sync7_q <= '0;
            syncr_q <= '1;
        end else begin
            sync6_q <= {sync6_q[SyncStages-2:0], pads.strap_dps6_i};
            sync7_q <= {sync7_q[SyncStages-2:0], pads.strap_dps7_i};
            syncr_q <= {syncr_q[SyncStages-2:0], pads.srst_ni};
        end
    end

    assign s_strap  = {sync7_q[SyncStages-1], sync6_q[SyncStages-1]};
    assign s_srst_n = syncr_q[SyncStages-1];

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        dcnt_d  = dcnt_q;
        scnt_d  = scnt_q;
        spi_d   = spi_q;
        boot_d  = boot_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_RESET: begin
                state_d = ST_SAMPLE;
                cand_d  = 2'b00;
                dcnt_d  = '0;
            end
            ST_SAMPLE: begin
                if (s_strap != cand_q) begin
                    cand_d = s_strap;
                    dcnt_d = '0;
                end else if (int'(dcnt_q) < DebounceCycles - 1) begin
                    dcnt_d = dcnt_q + DcntW'(1);
                end else begin
                    spi_d   = cand_q[0];
                    boot_d  = cand_q[1];
                    valid_d = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!s_srst_n) begin
                    state_d = ST_SRST;
                    scnt_d  = '0;
                    if (cnt_q != 8'hff) cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                if (int'(scnt_q) < SrstStretchCycles) scnt_d = scnt_q + ScntW'(1);
                if (int'(scnt_q) >= SrstStretchCycles - 1 && s_srst_n) state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= ST_RESET;
            cand_q    <= 2'b00;
            dcnt_q    <= '0;
            scnt_q    <= '0;
            rst_sys_q <= 1'b0;
            spi_q     <= 1'b0;
            boot_q    <= 1'b0;
            valid_q   <= 1'b0;
            cnt_q     <= 8'd0;
        end else begin
            state_q   <= state_d;
            cand_q    <= cand_d;
            dcnt_q    <= dcnt_d;
            scnt_q    <= scnt_d;
            rst_sys_q <= (state_d == ST_RUN);
            spi_q     <= spi_d;
            boot_q    <= boot_d;
            valid_q   <= valid_d;
            cnt_q     <= cnt_d;
        end
    end

    assign pads.rst_sys_no    = rst_sys_q;
    assign pads.dps_spi_sel_o = spi_q;
    assign pads.bootstrap_o   = boot_q;
    assign pads.mode_valid_o  = valid_q;
    assign pads.srst_cnt_o    = cnt_q;
    assign pads.state_o       = state_q;
endmodule

// File: doc/dps_strap_ctrl.md
# dps_strap_ctrl

Strap-sampling and reset sequencer for the debug pad straps on the FPGA top. It synchronises and debounces the JTAG/SPI select strap (DPS6) and the bootstrap strap (DPS7), then locks them. It holds the system reset until the strap values are stable, and stretches JTAG system-reset (SRST) requests to a guaranteed minimum width. It sits between the pad control block and the clock/reset generator: its outputs drive the padctl mode select, the bootstrap input and the core reset.

## Interface
Parameters:
- `SyncStages`, 2: synchroniser depth for all asynchronous pad inputs; must be ≥2.
- `DebounceCycles`, 16: consecutive stable cycles required before the straps are latched; must be ≥2.
- `SrstStretchCycles`, 64: minimum number of cycles `rst_sys_no` stays low per SRST event; must be ≥1.

Ports:
- `clk_i` input 1: system clock; the block's only clock.
- `rst_ni` input 1: synchronous, active-low reset.
- `strap_dps6_i` input 1: asynchronous strap; 0 selects JTAG, 1 selects SPI.
- `strap_dps7_i` input 1: asynchronous strap; 1 requests bootstrap.
- `srst_ni` input 1: asynchronous, active-low JTAG system reset request.
- `rst_sys_no` output 1: active-low system reset to the core.
- `dps_spi_sel_o` output 1: latched DPS6 value, driven to padctl.
- `bootstrap_o` output 1: latched DPS7 value.
- `mode_valid_o` output 1: straps have been latched.
- `srst_cnt_o` output 8: saturating count of SRST events.
- `state_o` output 2: FSM state; RESET=0, SAMPLE=1, RUN=2, SRST=3.

## Operation
- **Synchronisers.** Each asynchronous input passes through `SyncStages` flops. Straps reset to 0; `srst_ni` resets to 1. The synchronised values are called `s_strap[1:0]` (bit0 = DPS6, bit1 = DPS7) and `s_srst_n`.
- **RESET.** Entered while `rst_ni` = 0. All outputs are forced to their reset values. On the first edge with `rst_ni` = 1 the FSM moves to SAMPLE; `cand` = 2'b00 and `dcnt` = 0.
- **SAMPLE.** On every edge:
  - If `s_strap` ≠ `cand`: `cand` ← `s_strap`, `dcnt` ← 0.
  - Else if `dcnt` < `DebounceCycles`-1: `dcnt` increments.
  - Else latch: `dps_spi_sel_o` ← `cand[0]`, `bootstrap_o` ← `cand[1]`, `mode_valid_o` ← 1, FSM → RUN.
  - `s_srst_n` is ignored in SAMPLE; the core is already held in reset.
- **RUN.** `rst_sys_no` = 1. On an edge where `s_srst_n` = 0:
  - FSM → SRST, `scnt` ← 0.
  - `srst_cnt_o` increments, saturating at 255.
- **SRST.** `rst_sys_no` = 0. `scnt` increments each edge, saturating at `SrstStretchCycles`. FSM → RUN on the first edge where `scnt` ≥ `SrstStretchCycles`-1 and `s_srst_n` = 1.
- **Strap lock.** Straps are not re-sampled after SRST. `dps_spi_sel_o`, `bootstrap_o` and `mode_valid_o` change only in SAMPLE, and are cleared only by `rst_ni`.
- **Reset mid-operation.** `rst_ni` low in any state returns the FSM to RESET on that edge. All outputs take their reset values, including `srst_cnt_o` = 0.
- **Counter widths.**
  - `dcnt` width = $clog2(DebounceCycles).
  - `scnt` width = $clog2(SrstStretchCycles+1).
  - No wrap-around: `dcnt` is cleared on mismatch, and `scnt` saturates.

## Timing
- **Registered outputs.** All outputs are registered.
- **Reset values:**
  - `rst_sys_no` = 0
  - `dps_spi_sel_o` = 0
  - `bootstrap_o` = 0
  - `mode_valid_o` = 0
  - `srst_cnt_o` = 0
  - `state_o` = 0
- **Edge numbering.** Edge 0 is the first rising edge with `rst_ni` sampled high.
- **Strap latency, straps equal to the synchroniser reset value (00).** The latch happens at edge `DebounceCycles`. `rst_sys_no`, `mode_valid_o` and the mode outputs all rise after that edge, in the same cycle.
- **Strap latency, any strap bit at 1.** The synchroniser reflects the strap after edge `SyncStages`, and the mismatch is seen at edge `SyncStages`+1. The latch happens at edge `DebounceCycles`+`SyncStages`+1.
- **Glitch during SAMPLE.** A strap change restarts the count. The latch happens `DebounceCycles` edges after the last change is seen at the synchroniser output.
- **SRST entry.**
  - `srst_ni` low at the pad → `rst_sys_no` low after edge `SyncStages`+1.
  - `srst_cnt_o` updates on the same edge.
- **SRST exit.**
  - Short pulse (shorter than the stretch): `rst_sys_no` stays low for exactly `SrstStretchCycles` cycles.
  - Long pulse: `rst_sys_no` rises one edge after `s_srst_n` returns to 1.
- **Back-to-back SRST.** `srst_ni` low again on the same edge the FSM returns to RUN: RUN is held for one cycle, then a new SRST is entered and counted.

## Test plan
- **Straps 00, default parameters.** Release `rst_ni` → `rst_sys_no` and `mode_valid_o` = 1 after edge 16; `dps_spi_sel_o` = 0, `bootstrap_o` = 0.
- **Straps DPS6=1, DPS7=1.** → latch at edge 19; `dps_spi_sel_o` = 1, `bootstrap_o` = 1; `state_o` goes 0→1→2.
- **DPS6 toggled every 5 cycles for 40 cycles, then held at 1.** → no latch while toggling; latch exactly 16 edges after the last change reaches the synchroniser output.
- **In RUN, 3-cycle `srst_ni` low pulse.** → `rst_sys_no` low for exactly 64 cycles; `srst_cnt_o` = 1; straps unchanged even if the pads changed meanwhile.
- **In RUN, 200-cycle `srst_ni` low, then release.** → `rst_sys_no` low until `SyncStages`+1 edges after the pad release; 256 such events → `srst_cnt_o` saturates at 255.
- **`rst_ni` asserted during SRST at `scnt` = 10.** → all outputs return to their reset values on that edge; `srst_cnt_o` = 0; SAMPLE restarts on release.
